nes_button_events: RTL

NES_BUTTON_EVENTS -- requirements
Module: nes_button_events

---
 rtl/nes_pkg.sv | 16 +
 rtl/nes_button_chan.sv | 96 +++++++++
 rtl/nes_button_events.sv | 49 ++++
 3 files changed

// File: rtl/nes_pkg.sv
// nes_pkg: shared button bit indices and per-channel FSM state encoding
package nes_pkg;
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;
    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_HELD_DELAY  = 2'd1,
        ST_HELD_REPEAT = 2'd2
    } chan_state_t;
endpackage

// File: rtl/nes_button_chan.sv
// nes_button_chan: one button channel, debounce plus press/release/auto-repeat pulses
module nes_button_chan
    import nes_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_RATE   = 6,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw_n,
    input  logic i_valid,
    output logic o_held,
    output logic o_held_nxt,
    output logic o_pressed,
    output logic o_released,
    output logic o_repeat
);
    localparam logic [7:0] L_DC_MAX = 8'(STABLE_FRAMES - 1);
    localparam logic [7:0] L_DELAY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] L_RATE   = 8'(REPEAT_RATE);

    chan_state_t r_state, w_state;
    logic [7:0]  r_dcnt, w_dcnt, r_rcnt, w_rcnt, w_rinc, w_limit;
    logic        r_held, w_held, r_pressed, w_pressed, r_released, w_released, r_repeat, w_repeat;
    logic        w_diff, w_accept;

    // next-state: debounce the raw level, then step the press/repeat FSM on accepted edges
    always_comb begin
        w_state    = r_state;
        w_dcnt     = r_dcnt;
        w_rcnt     = r_rcnt;
        w_held     = r_held;
        w_pressed  = 1'b0;
        w_released = 1'b0;
        w_repeat   = 1'b0;
        w_diff     = ~i_raw_n ^ r_held;
        w_accept   = w_diff && (r_dcnt == L_DC_MAX);
        w_rinc     = r_rcnt + 8'd1;
        w_limit    = (r_state == ST_HELD_REPEAT) ? L_RATE : L_DELAY;
        if (i_valid) begin
            w_dcnt = (!w_diff || w_accept) ? 8'd0 : r_dcnt + 8'd1;
            w_held = r_held ^ w_accept;
            case (r_state)
                ST_RELEASED: begin
                    if (w_accept) begin
                        w_state   = ST_HELD_DELAY;
                        w_rcnt    = 8'd0;
                        w_pressed = 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        w_state    = ST_RELEASED;
                        w_rcnt     = 8'd0;
                        w_released = 1'b1;
                    end else if (REPEAT_EN && w_rinc == w_limit) begin
                        w_state  = ST_HELD_REPEAT;
                        w_rcnt   = 8'd0;
                        w_repeat = 1'b1;
                    end else if (r_rcnt != w_limit) begin
                        w_rcnt = w_rinc;
                    end
                end
            endcase
        end
    end

    // state and registered outputs; reset discards any partial debounce or repeat count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RELEASED;
            r_dcnt     <= 8'd0;
            r_rcnt     <= 8'd0;
            r_held     <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_dcnt     <= w_dcnt;
            r_rcnt     <= w_rcnt;
            r_held     <= w_held;
            r_pressed  <= w_pressed;
            r_released <= w_released;
            r_repeat   <= w_repeat;
        end
    end

    assign o_held     = r_held;
    assign o_held_nxt = w_held;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    assign o_repeat   = r_repeat;
endmodule

// File: rtl/nes_button_events.sv
// nes_button_events: eight independent button channels plus a registered any-held flag
module nes_button_events
    import nes_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_RATE   = 6,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rec_data,
    input  logic       frame_valid,
    output logic [7:0] held,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic [7:0] auto_repeat,
    output logic       any_held
);
    logic [7:0] w_held_nxt;
    logic       r_any_held;

    for (genvar i = 0; i < 8; i++) begin : g_chan
        nes_button_chan #(
            .STABLE_FRAMES (STABLE_FRAMES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE),
            .REPEAT_EN     (REPEAT_EN)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_raw_n    (rec_data[i]),
            .i_valid    (frame_valid),
            .o_held     (held[i]),
            .o_held_nxt (w_held_nxt[i]),
            .o_pressed  (pressed[i]),
            .o_released (released[i]),
            .o_repeat   (auto_repeat[i])
        );
    end

    // any_held is registered from the next held vector so it moves in the same cycle as held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           r_any_held <= 1'b0;
        else if (frame_valid) r_any_held <= |w_held_nxt;
    end

    assign any_held = r_any_held;
endmodule
